// File: rtl/alu_shift_core.sv
// ALU input shifter: pass-through or one-bit left/right shift of the data bus with a fill bit.
// Define SHIFTER_OUT_REG_EN to register out_high/out_low (1-cycle latency, async reset to 0).
module alu_shift_core (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] db,
   input  logic       shift_in,
   input  logic       shift_left,
   input  logic       shift_right,
   output logic       shift_db0,
   output logic       shift_db7,
   output logic [3:0] out_high,
   output logic [3:0] out_low,
   output logic       shift_cy
);

   logic [7:0] result;
   logic       cy_d;
   logic       cy_q;

   // Taps depend only on db, so SRA can feed shift_db7 back into shift_in without a loop.
   assign shift_db0 = db[0];
   assign shift_db7 = db[7];

   // Both-controls-set is illegal and falls back to pass-through with the carry held.
   always_comb begin
      result = db;
      cy_d   = cy_q;
      unique case ({shift_left, shift_right})
         2'b01: begin
            result = {shift_in, db[7:1]};
            cy_d   = db[0];
         end
         2'b10: begin
            result = {db[6:0], shift_in};
            cy_d   = db[7];
         end
         default: begin
            result = db;
            cy_d   = cy_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cy_q <= 1'b0;
      end else begin
         cy_q <= cy_d;
      end
   end

   assign shift_cy = cy_q;

`ifdef SHIFTER_OUT_REG_EN
   logic [7:0] result_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= 8'h00;
      end else begin
         result_q <= result;
      end
   end

   assign out_high = result_q[7:4];
   assign out_low  = result_q[3:0];
`else
   assign out_high = result[7:4];
   assign out_low  = result[3:0];
`endif

endmodule

// File: tb/tb_alu_shift_core.sv
// Directed self-checking bench for alu_shift_core; each step drives one vector and checks
// the result, the db taps and the captured carry after the following clock edge.
module tb_alu_shift_core;

   logic       clk;
   logic       reset;
   logic [7:0] db;
   logic       shift_in;
   logic       shift_left;
   logic       shift_right;
   logic       shift_db0;
   logic       shift_db7;
   logic [3:0] out_high;
   logic [3:0] out_low;
   logic       shift_cy;

   int checks = 0;
   int errors = 0;

   alu_shift_core dut (
      .clk         (clk),
      .reset       (reset),
      .db          (db),
      .shift_in    (shift_in),
      .shift_left  (shift_left),
      .shift_right (shift_right),
      .shift_db0   (shift_db0),
      .shift_db7   (shift_db7),
      .out_high    (out_high),
      .out_low     (out_low),
      .shift_cy    (shift_cy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // Entered and left at posedge+1.
   task automatic step(input string tag, input logic [7:0] d, input logic sin,
                       input logic l, input logic r, input logic [7:0] exp_r,
                       input logic exp_cy);
      db          = d;
      shift_in    = sin;
      shift_left  = l;
      shift_right = r;
      #1;
      check1({tag, " db0"}, shift_db0, d[0]);
      check1({tag, " db7"}, shift_db7, d[7]);
`ifndef SHIFTER_OUT_REG_EN
      check8({tag, " R"}, {out_high, out_low}, exp_r);
`endif
      @(posedge clk);
      #1;
`ifdef SHIFTER_OUT_REG_EN
      check8({tag, " R"}, {out_high, out_low}, exp_r);
`endif
      check1({tag, " cy"}, shift_cy, exp_cy);
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] exp_r;
      reset       = 1'b1;
      db          = 8'h00;
      shift_in    = 1'b0;
      shift_left  = 1'b0;
      shift_right = 1'b0;
      #2;
      check1("reset cy", shift_cy, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Pass-through; shift_in ignored
      step("pass AA", 8'hAA, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0);
      step("pass 55", 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);

      step("right 01", 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      step("right 80", 8'h80, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0);
      step("left 80",  8'h80, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      step("left 40",  8'h40, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0);
      step("right 08", 8'h08, 1'b1, 1'b0, 1'b1, 8'h84, 1'b0);

      // Walking one, both directions, both fill values
      for (int i = 0; i < 8; i++) begin
         for (int s = 0; s < 2; s++) begin
            w     = 8'h01 << i;
            exp_r = (w >> 1) | (s[0] ? 8'h80 : 8'h00);
            step("walk right", w, s[0], 1'b0, 1'b1, exp_r, (i == 0));
            exp_r = (w << 1) | (s[0] ? 8'h01 : 8'h00);
            step("walk left", w, s[0], 1'b1, 1'b0, exp_r, (i == 7));
         end
      end

      // SRA: fill with db[7]
      step("sra 80", 8'h80, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0);
      step("sra 01", 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
      step("sra 81", 8'h81, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b1);

      // Carry is 1 here; db[0] and db[7] are 0 so any spurious load would clear it
      step("both 3C", 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1);
      step("hold 7E", 8'h7E, 1'b1, 1'b0, 1'b0, 8'h7E, 1'b1);

      // Asynchronous reset mid-cycle
      #2;
      reset = 1'b1;
      #1;
      check1("async reset cy", shift_cy, 1'b0);
`ifndef SHIFTER_OUT_REG_EN
      check8("R during reset", {out_high, out_low}, 8'h7E);
`endif
      check1("db7 during reset", shift_db7, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("after reset", 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
